seq_gen: RTL
============

// Module: seq_gen
// PURPOSE
//   Serial pattern transmitter: drives the x stream consumed by the 110010/110110 sequence
//   detector. On a start request it shifts out one of two LEN-bit patterns, MSB first.
//   The pattern is chosen by btn: btn=1 sends PAT_A (110010), btn=0 sends PAT_B (110110).
//   The frame can repeat up to 15 times, with an optional idle gap between repetitions.
//   Sits between the button/switch front end and the detector input on the same clock.
// PARAMETERS
//   LEN         6          pattern length in bits (2..16)
//   PAT_A       6'b110010  pattern sent when btn=1 at start
//   PAT_B       6'b110110  pattern sent when btn=0 at start
//   BIT_CYCLES  1          clocks each bit is held on x (>=1)
//   GAP_CYCLES  0          idle clocks (x=0, x_valid=0) between repetitions (0 = back-to-back)
// PORTS
//   clk      in   1  system clock; all state updates on posedge
//   rst      in   1  synchronous, active-high reset
//   start    in   1  request a transmission; sampled only in IDLE
//   btn      in   1  pattern select; latched at accepted start
//   reps     in   4  repetition count; latched at accepted start; 0 treated as 1
//   abort    in   1  synchronous cancel of an in-progress transmission
//   x        out  1  serial data bit to detector
//   x_valid  out  1  high while x carries a pattern bit
//   busy     out  1  high from the first bit through the last bit/gap
//   done     out  1  one-cycle pulse after the final bit of the final repetition
// BEHAVIOUR
//   Reset (rst=1 at a posedge): state=IDLE; x=0, x_valid=0, busy=0, done=0; all counters cleared.
//   rst overrides every other input in the same cycle, including mid-frame.
//   All outputs are registered.
//   States:
//     IDLE: outputs 0. On start=1, latch sel=btn and rep_left=(reps==0 ? 1 : reps),
//           load shift reg with PAT_A or PAT_B, go to SEND.
//     SEND: x=shreg[LEN-1], x_valid=1, busy=1. Each bit is held BIT_CYCLES clocks, then
//           shreg shifts left by 1. After LEN bits, rep_left is decremented.
//           If rep_left is still >0: reload the same pattern and go to GAP, or straight
//           to SEND if GAP_CYCLES=0 (no dead cycle between repetitions).
//           Otherwise go to DONE.
//     GAP:  x=0, x_valid=0, busy=1 for GAP_CYCLES clocks, then SEND.
//     DONE: done=1, busy=0, x=0, x_valid=0 for exactly 1 cycle, then IDLE.
//   Latency: start high at posedge N puts the first bit (MSB) on x after posedge N+1.
//   The frame is LEN*BIT_CYCLES clocks.
//   Total from start to done:
//     reps*LEN*BIT_CYCLES + (reps-1)*GAP_CYCLES + 1.
//   start is ignored in SEND, GAP and DONE; no queuing.
//   A start asserted in the same cycle as done is dropped.
//   btn and reps changes after an accepted start have no effect until the next start.
//   abort=1 in SEND or GAP: next cycle is IDLE with all outputs 0 and no done pulse.
//   abort in IDLE or DONE has no effect. abort and start together in IDLE: abort wins,
//   start is dropped.
//   Counters:
//     bit index: $clog2(LEN) bits, saturating compare at LEN-1
//     period:    $clog2(BIT_CYCLES+1) bits
//     rep:       4 bits, never wraps (0 is mapped to 1 at latch)
// TESTING
//   1. rst; start=1 for one cycle with btn=1, reps=1 -> x=1,1,0,0,1,0 on cycles 1-6;
//      x_valid=1 for those 6 cycles; done=1 on cycle 7 only.
//   2. Same as 1 with btn=0 -> x=1,1,0,1,1,0. Drive a seq_detect from x with the same btn
//      and check z pulses once per frame.
//   3. reps=3, GAP_CYCLES=0 -> 18 contiguous x_valid cycles (pattern x3), done on cycle 19.
//      Repeat with reps=0 -> identical to reps=1.
//   4. BIT_CYCLES=4, GAP_CYCLES=2, reps=2 -> each bit held 4 clocks; 2-cycle x_valid=0 gap
//      between frames; done at cycle 51.
//   5. Pulse start and toggle btn at cycle 3 of a frame -> frame unchanged, no second frame.
//      start on the done cycle -> dropped.
//   6. rst or abort at cycle 4 of a frame -> next cycle x=0, x_valid=0, busy=0, done never
//      pulses; a fresh start afterwards transmits normally.

Source files
------------

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts one of two LEN-bit patterns out on x, MSB first,
// optionally repeated with idle gaps, for the 110010/110110 sequence detector.
module seq_gen #(
    parameter int             LEN        = 6,
    parameter logic [LEN-1:0] PAT_A      = 6'b110010,
    parameter logic [LEN-1:0] PAT_B      = 6'b110110,
    parameter int             BIT_CYCLES = 1,
    parameter int             GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn,
    input  logic [3:0] reps,
    input  logic       abort,
    output logic       x,
    output logic       x_valid,
    output logic       busy,
    output logic       done
);

    localparam int BW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int PW = $clog2(BIT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [BW-1:0] BIT_LAST = BW'(LEN - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    logic [LEN-1:0] shreg_r;
    logic           sel_r;
    logic [3:0]     rep_r;
    logic [BW-1:0]  bit_r;
    logic [PW-1:0]  per_r;
    logic [GW-1:0]  gap_r;

    function automatic logic [LEN-1:0] pattern_for(input logic sel);
        return sel ? PAT_A : PAT_B;
    endfunction

    // Sequencer: the outputs register what the current state emits, so the first bit
    // appears one clock after the state enters SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= '0;
            sel_r   <= 1'b0;
            rep_r   <= 4'd0;
            bit_r   <= '0;
            per_r   <= '0;
            gap_r   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort && ((state_r == SEND) || (state_r == GAP))) begin
            state_r <= IDLE;
            shreg_r <= '0;
            rep_r   <= 4'd0;
            bit_r   <= '0;
            per_r   <= '0;
            gap_r   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    // A start seen while done is still showing belongs to the old frame.
                    if (start && !abort && !done) begin
                        sel_r   <= btn;
                        rep_r   <= (reps == 4'd0) ? 4'd1 : reps;
                        shreg_r <= pattern_for(btn);
                        bit_r   <= '0;
                        per_r   <= '0;
                        gap_r   <= '0;
                        state_r <= SEND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    x       <= shreg_r[LEN-1];
                    x_valid <= 1'b1;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    if (per_r == PER_LAST) begin
                        per_r <= '0;
                        if (bit_r >= BIT_LAST) begin
                            bit_r <= '0;
                            if (rep_r != 4'd0) begin
                                rep_r <= rep_r - 4'd1;
                            end else begin
                                rep_r <= 4'd0;
                            end
                            if (rep_r > 4'd1) begin
                                shreg_r <= pattern_for(sel_r);
                                gap_r   <= '0;
                                state_r <= (GAP_CYCLES == 0) ? SEND : GAP;
                            end else begin
                                state_r <= DONE;
                            end
                        end else begin
                            bit_r   <= bit_r + BW'(1);
                            shreg_r <= {shreg_r[LEN-2:0], 1'b0};
                        end
                    end else begin
                        per_r <= per_r + PW'(1);
                    end
                end
                GAP: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    if (gap_r == GAP_LAST) begin
                        gap_r   <= '0;
                        state_r <= SEND;
                    end else begin
                        gap_r <= gap_r + GW'(1);
                    end
                end
                DONE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
